// File: rtl/t_state_sequencer.sv
// t_state_sequencer
// One-hot T-state ring sequencer for the SAP-1 controller/sequencer.
// Generates T1..TN (MSB = T1) with a matching binary index, and supports
// variable-length instructions (early end after the fetch phase),
// single-stepping on the rising edge of step, HLT latching and a wrapping
// completed-instruction counter. All state updates on the falling edge of
// clk, so the bus registers that latch on the rising edge see stable
// control signals.
//
// Parameters:
//   NUM_STATES   T-states per full instruction cycle (>= 2)
//   FETCH_STATES leading T-states that form the fetch phase (1..NUM_STATES-1)
//   CNT_W        width of instr_cnt
//   IDX_W        derived, $clog2(NUM_STATES), width of t_idx
//
// Ports:
//   clk        in   system clock, state updates on negedge
//   res        in   synchronous active-high reset, sampled on negedge
//   run        in   1 = free-run, 0 = single-step mode
//   step       in   single-step request, rising edge gives one advance
//   hlt        in   HLT decoded, latches halted
//   early_end  in   current instruction ends after this T-state
//   t          out  one-hot T-state
//   t_idx      out  binary T-state index (0 = T1)
//   fetch      out  high while in the fetch phase
//   last       out  high when the next advance returns to T1
//   halted     out  high once HLT has been taken
//   instr_cnt  out  count of completed instructions, wraps
module t_state_sequencer #(
    parameter int NUM_STATES   = 6,
    parameter int FETCH_STATES = 3,
    parameter int CNT_W        = 8,
    localparam int IDX_W       = $clog2(NUM_STATES)
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  run,
    input  logic                  step,
    input  logic                  hlt,
    input  logic                  early_end,
    output logic [NUM_STATES-1:0] t,
    output logic [IDX_W-1:0]      t_idx,
    output logic                  fetch,
    output logic                  last,
    output logic                  halted,
    output logic [CNT_W-1:0]      instr_cnt
);

    localparam logic [NUM_STATES-1:0] T1        = {1'b1, {(NUM_STATES-1){1'b0}}};
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_STATES - 1);
    localparam logic [IDX_W-1:0]      FETCH_IDX = IDX_W'(FETCH_STATES);

    // Operating mode is derived purely from run and the halted flop; it
    // exists to make the advance decision read like the controller's
    // mode diagram rather than a tangle of gates.
    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STEP,
        MODE_HALTED
    } mode_e;

    logic [NUM_STATES-1:0] t_q, t_d;
    logic [IDX_W-1:0]      t_idx_q, t_idx_d;
    logic                  halted_q, halted_d;
    logic [CNT_W-1:0]      instr_cnt_q, instr_cnt_d;
    logic                  step_q, step_d;

    mode_e mode;
    logic  step_rise;
    logic  adv;
    logic  in_fetch;
    logic  end_cond;
    logic  t_legal;

    // Pick the operating mode. Halted dominates; otherwise the run level
    // chooses between free-running and single-step.
    always_comb begin
        mode = MODE_STEP;
        if (halted_q) begin
            mode = MODE_HALTED;
        end else if (run) begin
            mode = MODE_RUN;
        end
    end

    // Advance qualification and end-of-instruction detection. early_end is
    // masked during the fetch phase so a fetch can never be truncated. The
    // t/t_idx consistency check lets a corrupted ring fall back to T1 on
    // the next advance instead of circulating a bad pattern.
    always_comb begin
        step_rise = step & ~step_q;
        adv       = ~hlt & ((mode == MODE_RUN) | ((mode == MODE_STEP) & step_rise));
        in_fetch  = (t_idx_q < FETCH_IDX);
        end_cond  = (t_idx_q == LAST_IDX) | (early_end & ~in_fetch);
        t_legal   = (t_idx_q <= LAST_IDX) && (t_q == (T1 >> t_idx_q));
    end

    // Next-state logic. A fresh hlt freezes the ring and the counter in
    // the same cycle it is taken, which is why it outranks an advance and
    // why a simultaneous early_end does not count the instruction.
    always_comb begin
        t_d         = t_q;
        t_idx_d     = t_idx_q;
        halted_d    = halted_q;
        instr_cnt_d = instr_cnt_q;
        step_d      = step;
        if (hlt && !halted_q) begin
            halted_d = 1'b1;
        end else if (adv) begin
            if (!t_legal) begin
                t_d     = T1;
                t_idx_d = '0;
            end else if (end_cond) begin
                t_d         = T1;
                t_idx_d     = '0;
                instr_cnt_d = instr_cnt_q + CNT_W'(1);
            end else begin
                t_d     = t_q >> 1;
                t_idx_d = t_idx_q + IDX_W'(1);
            end
        end
    end

    // State registers on the falling edge. Reset captures the current step
    // level so a step held across reset release does not fire an advance.
    always_ff @(negedge clk) begin
        if (res) begin
            t_q         <= T1;
            t_idx_q     <= '0;
            halted_q    <= 1'b0;
            instr_cnt_q <= '0;
            step_q      <= step;
        end else begin
            t_q         <= t_d;
            t_idx_q     <= t_idx_d;
            halted_q    <= halted_d;
            instr_cnt_q <= instr_cnt_d;
            step_q      <= step_d;
        end
    end

    // Outputs. fetch and last are combinational so control decode sees
    // early_end in the same T-state it is raised.
    always_comb begin
        t         = t_q;
        t_idx     = t_idx_q;
        halted    = halted_q;
        instr_cnt = instr_cnt_q;
        fetch     = in_fetch;
        last      = end_cond;
    end

endmodule
